// File: rtl/exp_block.sv
// exp(x) for the softmax datapath: signed Q7.8 in, unsigned Q5.11 out.
// Base-2 range reduction, interpolated 2^f table, barrel shift; 4-stage valid/ready pipe.
module exp_block (
    input  logic        iClk,
    input  logic        iRsn,
    input  logic        iValid,
    output logic        oReady,
    input  logic [15:0] iData,
    output logic        oValid,
    input  logic        iReady,
    output logic [15:0] oData
);

    // log2(e) as unsigned Q1.15, zero-extended so the product stays signed
    localparam logic signed [32:0] LOG2E = 33'sh0B8AA;

    logic [15:0] lut [256];

    for (genvar g = 0; g < 256; g++) begin : g_lut
        localparam real         R = 2.0 ** (real'(g) / 256.0);
        localparam int unsigned V = $rtoi(R * 32768.0 + 0.5);
        assign lut[g] = V[15:0];
    end

    function automatic logic signed [18:0] round_q810(input logic signed [32:0] prod);
        return 19'((prod + 33'sd4096) >>> 13);
    endfunction

    // m is 2^f in Q1.15, so Q5.11 output is m * 2^(k-4) with half-up rounding
    function automatic logic [15:0] scale_sat(input logic [15:0] m, input logic signed [8:0] k);
        logic [4:0]  sh;
        logic [16:0] sum;
        if (k > 9'sd4)
            return 16'hFFFF;
        if (k == 9'sd4)
            return m;
        if (k < -9'sd12)
            return 16'h0000;
        sh  = 5'(9'sd4 - k);
        sum = {1'b0, m} + (17'd1 << (sh - 5'd1));
        return 16'(sum >> sh);
    endfunction

    logic               rdy_p1, rdy_p2, rdy_p3, rdy_p4;
    logic signed [32:0] prod_s1;
    logic signed [18:0] t_s1;
    logic [7:0]         addr_s2;
    logic [15:0]        delta_s3;
    logic [17:0]        dprod_s3;
    logic [15:0]        m_s3;

    logic               vld_p1_q, vld_p1_d;
    logic signed [8:0]  k_p1_q, k_p1_d;
    logic [9:0]         f_p1_q, f_p1_d;
    logic               vld_p2_q, vld_p2_d;
    logic [15:0]        y0_p2_q, y0_p2_d, y1_p2_q, y1_p2_d;
    logic [1:0]         frac_p2_q, frac_p2_d;
    logic [7:0]         addr_p2_q, addr_p2_d;
    logic signed [8:0]  k_p2_q, k_p2_d;
    logic               vld_p3_q, vld_p3_d;
    logic [15:0]        res_p3_q, res_p3_d;
    logic               vld_p4_q, vld_p4_d;
    logic [15:0]        res_p4_q, res_p4_d;

    always_comb begin
        rdy_p4 = !vld_p4_q || iReady;
        rdy_p3 = !vld_p3_q || rdy_p4;
        rdy_p2 = !vld_p2_q || rdy_p3;
        rdy_p1 = !vld_p1_q || rdy_p2;
        oReady = rdy_p1;
        oValid = vld_p4_q;
        oData  = res_p4_q;

        // Stage 1: range reduction to k + f in log2 domain
        prod_s1  = 33'($signed(iData)) * LOG2E;
        t_s1     = round_q810(prod_s1);
        vld_p1_d = vld_p1_q;
        k_p1_d   = k_p1_q;
        f_p1_d   = f_p1_q;
        if (rdy_p1) begin
            vld_p1_d = iValid;
            if (iValid) begin
                k_p1_d = t_s1[18:10];
                f_p1_d = t_s1[9:0];
            end
        end

        // Stage 2: table lookup of both interpolation endpoints
        addr_s2   = f_p1_q[9:2];
        vld_p2_d  = vld_p2_q;
        y0_p2_d   = y0_p2_q;
        y1_p2_d   = y1_p2_q;
        frac_p2_d = frac_p2_q;
        addr_p2_d = addr_p2_q;
        k_p2_d    = k_p2_q;
        if (rdy_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                y0_p2_d   = lut[addr_s2];
                y1_p2_d   = lut[addr_s2 + 8'd1];
                frac_p2_d = f_p1_q[1:0];
                addr_p2_d = addr_s2;
                k_p2_d    = k_p1_q;
            end
        end

        // Stage 3: interpolate, then shift by the integer exponent
        delta_s3 = (addr_p2_q == 8'hFF) ? 16'd0 : y1_p2_q - y0_p2_q;
        dprod_s3 = {2'b00, delta_s3} * {16'd0, frac_p2_q};
        m_s3     = 16'(y0_p2_q + (dprod_s3 >> 2));
        vld_p3_d = vld_p3_q;
        res_p3_d = res_p3_q;
        if (rdy_p3) begin
            vld_p3_d = vld_p2_q;
            if (vld_p2_q)
                res_p3_d = scale_sat(m_s3, k_p2_q);
        end

        // Stage 4: output register
        vld_p4_d = vld_p4_q;
        res_p4_d = res_p4_q;
        if (rdy_p4) begin
            vld_p4_d = vld_p3_q;
            if (vld_p3_q)
                res_p4_d = res_p3_q;
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            vld_p1_q  <= 1'b0;
            k_p1_q    <= '0;
            f_p1_q    <= '0;
            vld_p2_q  <= 1'b0;
            y0_p2_q   <= '0;
            y1_p2_q   <= '0;
            frac_p2_q <= '0;
            addr_p2_q <= '0;
            k_p2_q    <= '0;
            vld_p3_q  <= 1'b0;
            res_p3_q  <= '0;
            vld_p4_q  <= 1'b0;
            res_p4_q  <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            k_p1_q    <= k_p1_d;
            f_p1_q    <= f_p1_d;
            vld_p2_q  <= vld_p2_d;
            y0_p2_q   <= y0_p2_d;
            y1_p2_q   <= y1_p2_d;
            frac_p2_q <= frac_p2_d;
            addr_p2_q <= addr_p2_d;
            k_p2_q    <= k_p2_d;
            vld_p3_q  <= vld_p3_d;
            res_p3_q  <= res_p3_d;
            vld_p4_q  <= vld_p4_d;
            res_p4_q  <= res_p4_d;
        end
    end

endmodule

// File: tb/tb_exp_block.sv
// Bench for exp_block: scoreboard of accepted words, each expected value computed
// from the exp/2^f definitions with plain arithmetic, compared on every cycle.
module tb_exp_block;

    logic        iClk = 1'b0;
    logic        iRsn;
    logic        iValid;
    logic        oReady;
    logic [15:0] iData;
    logic        oValid;
    logic        iReady;
    logic [15:0] oData;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_q[$];
    int acc_q[$];
    bit rand_rdy = 1'b0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    exp_block dut (
        .iClk(iClk), .iRsn(iRsn), .iValid(iValid), .oReady(oReady),
        .iData(iData), .oValid(oValid), .iReady(iReady), .oData(oData)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    function automatic int lut_ref(input int a);
        return $rtoi(32768.0 * (2.0 ** (real'(a) / 256.0)) + 0.5);
    endfunction

    // 2^(x*log2e) with the table mantissa, scaled to Q5.11, rounded, clamped
    function automatic int model_exp(input logic [15:0] x);
        longint t;
        int k, f, a, y0, d;
        real m, r;
        t  = (longint'($signed(x)) * 47274 + 4096) >>> 13;
        k  = int'(t >>> 10);
        f  = int'(t & 1023);
        a  = f / 4;
        y0 = lut_ref(a);
        d  = (a == 255) ? 0 : lut_ref(a + 1) - y0;
        m  = real'(y0 + (d * (f % 4)) / 4);
        r  = $floor(m * (2.0 ** real'(k - 4)) + 0.5);
        if (r > 65535.0)
            return 65535;
        return $rtoi(r);
    endfunction

    function automatic int golden(input logic [15:0] x);
        real r;
        r = $exp(real'($signed(x)) / 256.0) * 2048.0;
        if (r > 65535.0)
            return 65535;
        return $rtoi(r + 0.5);
    endfunction

    function automatic bit near(input int a, input int b);
        return (a - b <= 2) && (b - a <= 2);
    endfunction

    // Compare process: sampled mid-cycle, away from the rising edge
    always @(negedge iClk) begin
        cyc++;
        if (!iRsn) begin
            chk("rst_ovalid", oValid, 0);
            chk("rst_odata", oData, 0);
            chk("rst_oready", oReady, 1);
            exp_q.delete();
            acc_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("ovalid", oValid, (exp_q.size() > 0 && cyc >= acc_q[0] + 4) ? 1 : 0);
            chk("oready", oReady, (exp_q.size() < 4 || iReady) ? 1 : 0);
            if (prev_stall)
                chk("stall_hold", oData, prev_data);
            if (oValid && exp_q.size() > 0)
                chk("odata", oData, exp_q[0]);
            if (oValid && iReady && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            prev_stall = oValid && !iReady;
            prev_data  = oData;
            if (iValid && oReady) begin
                exp_q.push_back(model_exp(iData));
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
        if (rand_rdy)
            iReady = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] x);
        bit ok;
        int n;
        iValid = 1'b1;
        iData  = x;
        n = 0;
        do begin
            #1;
            ok = oReady;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok)
            chk("send_timeout", 0, 1);
        iValid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic latency_check(input string name, input logic [15:0] x);
        int n;
        send(x);
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!oValid && n < 10);
        chk({name, "_lat"}, n, 4);
        chk({name, "_data"}, oData, model_exp(x));
        @(negedge iClk);
        chk({name, "_pulse"}, oValid, 0);
        tick();
    endtask

    logic [15:0] spots [6] = '{16'h0000, 16'h0380, 16'hF800, 16'hF000, 16'hFF00, 16'h0100};
    logic [15:0] w [6];

    initial begin
        int c0, idx, acc;
        iRsn = 1'b0; iValid = 1'b0; iData = '0; iReady = 1'b1;

        chk("pin_model_0000", model_exp(16'h0000), 16'h0800);
        chk("pin_model_0380", model_exp(16'h0380), 16'hFFFF);
        chk("pin_model_f800", model_exp(16'hF800), 16'h0001);
        chk("pin_model_f000", model_exp(16'hF000), 16'h0000);
        chk("pin_model_ff00", near(model_exp(16'hFF00), 753), 1);
        chk("pin_model_0100", near(model_exp(16'h0100), 5567), 1);
        foreach (spots[i])
            chk("pin_golden", near(model_exp(spots[i]), golden(spots[i])), 1);

        repeat (3) tick();
        chk("reset_ovalid", oValid, 0);
        chk("reset_odata", oData, 16'h0000);
        chk("reset_oready", oReady, 1);
        iRsn = 1'b1;
        #1;
        chk("release_oready", oReady, 1);
        tick();

        // exact point with latency and single-cycle pulse
        latency_check("exact_0000", 16'h0000);
        chk("exact_0000_lit", model_exp(16'h0000), 16'h0800);

        foreach (spots[i]) send(spots[i]);
        wait_drain();

        // full-code sweep, back-to-back
        c0 = cyc;
        for (int i = 0; i < 65536; i++) send(16'(i));
        chk("sweep_cycles", cyc - c0, 65536);
        wait_drain();

        // bubbles: alternate valid, pattern must appear 4 cycles later
        for (int n = 0; n < 18; n++) begin
            iValid = (n < 12 && n % 2 == 0);
            iData  = 16'($urandom);
            @(negedge iClk);
            chk("bubble_ovalid", oValid, (n >= 4 && (n - 4) % 2 == 0 && n - 4 < 12) ? 1 : 0);
            tick();
        end
        iValid = 1'b0;
        wait_drain();

        // random backpressure burst
        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) send(16'($urandom));
        wait_drain();
        rand_rdy = 1'b0;
        iReady = 1'b1;
        tick();

        // full stall: 4 accepted, then drain of all 6 on consecutive cycles
        foreach (w[i]) w[i] = 16'($urandom_range(16'hF000, 16'hFFFF));
        iReady = 1'b0;
        idx = 0;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            iValid = (idx < 6);
            iData  = (idx < 6) ? w[idx] : 16'h0;
            #1;
            if (iValid && oReady) begin acc++; idx++; end
            tick();
        end
        chk("stall_accepted", acc, 4);
        chk("stall_oready", oReady, 0);
        iReady = 1'b1;
        for (int n = 0; n < 10; n++) begin
            iValid = (idx < 6);
            iData  = (idx < 6) ? w[idx] : 16'h0;
            #1;
            if (iValid && oReady) idx++;
            @(negedge iClk);
            chk("stall_drain_ovalid", oValid, (n < 6) ? 1 : 0);
            tick();
        end
        iValid = 1'b0;
        wait_drain();

        // random mix of valid, ready and data
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            iValid = 1'($urandom_range(0, 1));
            iData  = 16'($urandom);
            tick();
        end
        iValid = 1'b0;
        wait_drain();
        rand_rdy = 1'b0;
        iReady = 1'b1;
        tick();

        // reset with 3 words in flight, oldest already at the output
        for (int i = 0; i < 3; i++) send(16'($urandom_range(0, 16'h02FF)));
        tick();
        chk("pre_rst_ovalid", oValid, 1);
        iRsn = 1'b0;
        #1;
        chk("async_rst_ovalid", oValid, 0);
        chk("async_rst_odata", oData, 16'h0000);
        chk("async_rst_oready", oReady, 1);
        tick();
        iRsn = 1'b1;
        repeat (6) tick();
        latency_check("post_rst", 16'h0100);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exp_block.md
# exp_block

Pipelined fixed-point exponential unit for the softmax datapath, the inverse of the natural-log block. It accepts signed Q7.8 log-domain values, typically `x - max - ln(sum)`, and returns `exp(x)` as unsigned Q5.11. It uses base-2 range reduction, a 256-entry 2^f LUT with 2-bit linear interpolation, and a barrel shift. It is a 4-stage valid/ready pipeline with full throughput and per-stage backpressure.

## Interface
- No parameters. Constants are fixed:
  - LOG2E = 16'hB8AA (1.4426950 in unsigned Q1.15).
  - LUT width 16b, unsigned Q1.15.
- `iClk`  in  1  single clock, rising edge.
- `iRsn`  in  1  reset, asynchronous, active-low.
- `iValid`  in  1  input word valid.
- `oReady`  out  1  block can accept input this cycle.
- `iData`  in  16  signed Q7.8 operand.
- `oValid`  out  1  output word valid.
- `iReady`  in  1  downstream accepts output.
- `oData`  out  16  unsigned Q5.11 `exp(iData)`.

## Operation
- **S1, range reduction**
  - `prod = iData * LOG2E`: signed 16b × unsigned 16b, giving signed Q8.23 in 33b.
  - `t = (prod + 2^12) >>> 13`: half-up rounding to signed Q8.10, held in 19b.
  - Register `k = t >>> 10`: floor, signed 9b, range −185..184.
  - Register `f = t[9:0]`: unsigned fraction.
- **S2, LUT lookup**
  - `addr = f[9:2]`.
  - `y0 = LUT[addr]`, `y1 = LUT[addr+1]`.
  - `LUT[a] = round(2^(a/256) * 32768)`, so `LUT[0] = 32768`.
  - Register `y0`, `y1`, `frac = f[1:0]`, `addr`, and `k`.
- **S3, interpolate and scale**
  - `delta = (addr==255) ? 0 : y1 - y0`.
  - `m = y0 + ((delta * frac) >> 2)`: unsigned Q1.15, range 32768..65535.
  - `k >= 5`: result 16'hFFFF (saturate).
  - `k == 4`: result = `m`.
  - `k <= 3`: `s = 4 - k`.
    - `s >= 17`: result 0.
    - Otherwise result = `(m + 2^(s-1)) >> s`, computed in 17b; the result always fits in 16b.
- **S4**: output register drives `oData`.
- No error flags. Out-of-range inputs saturate to 16'hFFFF or flush to 0.

## Timing
- **Reset**
  - All stage valids are 0, so `oValid = 0`.
  - All data registers are 0, so `oData = 16'h0000`.
  - `oReady = 1` while in reset and right after release.
- **Ready chain**
  - `ready4 = !v4 || iReady`.
  - `readyN = !vN || ready(N+1)` for N = 3..1.
  - `oReady = ready1`. It is combinational, so `oReady` may depend on `iReady` in the same cycle.
- **Stage advance**
  - A stage loads when its ready is high.
  - Its valid takes the upstream valid.
  - Its data is captured only when the upstream valid is 1; otherwise the data register holds.
- **Latency**: a word accepted at edge N (`iValid & oReady`) appears with `oValid = 1` after edge N+4.
- **Throughput**: 1 word/cycle with `iReady` held high.
- **Stall**
  - With `oValid & !iReady`, `oData` and `oValid` hold stable.
  - Bubbles compress; up to 4 words are held in flight.
  - `oReady` drops only when all 4 stages are valid and `iReady = 0`.
- **Simultaneous events**: a stage holding a valid word can drain and refill on the same edge.
- **Reset mid-operation**
  - Asynchronous clear of all valids; in-flight words are dropped.
  - `oValid` falls immediately on `iRsn` low, without waiting for an edge.
- **Ordering**: in-order, with no reordering or duplication.

## Test plan
- **Exact point**: `iData = 16'h0000` with `iReady = 1` → `oData = 16'h0800` exactly 4 cycles after acceptance, `oValid` pulses for 1 cycle.
- **Golden sweep**
  - Stimulus: all 65536 input codes, streamed back-to-back.
  - Reference: `min(round(e^x * 2048), 65535)`.
  - Pass criteria: `|error| <= 2` LSB, with exact values 0x0800 @ 0x0000, 0xFFFF @ 0x0380 (3.5), 0x0001 @ 0xF800 (−8.0), and 0x0000 @ 0xF000 (−16.0).
  - Also spot-check 0xFF00 (−1.0) → 753 ±2 and 0x0100 (1.0) → 5567 ±2.
- **Backpressure**
  - Stimulus: 10-word burst, `iReady` random at 50%.
  - Pass criteria: output order matches input; `oData` stable while `oValid & !iReady`; `oReady` low only when 4 words are held and `iReady = 0`.
- **Full stall**
  - Stimulus: `iReady = 0`, drive 6 valid words.
  - Pass criteria: exactly 4 accepted, `oReady = 0` afterwards; raise `iReady` → 4 outputs on consecutive cycles, then the remaining 2 follow.
- **Bubbles**: `iValid` alternating 1/0 → outputs alternate, each with latency 4, and no spurious `oValid`.
- **Reset mid-stream**
  - Stimulus: assert `iRsn = 0` for 1 cycle with 3 words in flight.
  - Pass criteria: `oValid = 0` and `oData = 0` immediately, no stale word after release, and the next input produces a correct result after 4 cycles.
